// File: rtl/aes_spi_frame_slave.sv
// Framed serial slave: cmd/msg/key in on SIMO, one AES launch, result out on SOMI (1 bit/clk, no backpressure).
// Key reuse (cmd[1]) exists only when SPI_SLAVE_KEY_REUSE_EN is defined; otherwise cmd[1]=1 is rejected.
module aes_spi_frame_slave #(
  parameter int DATA_W = 128,
  parameter int KEY_W  = 128,
  parameter int CMD_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              SIMO,
  output logic              SOMI,
  output logic              core_start,
  output logic [DATA_W-1:0] core_msg,
  output logic [KEY_W-1:0]  core_key,
  output logic              core_decrypt,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              busy,
  output logic              err
);

  localparam int MAX_DK = (DATA_W > KEY_W) ? DATA_W : KEY_W;
  localparam int MAX_W  = (MAX_DK > CMD_W) ? MAX_DK : CMD_W;
  localparam int CNT_W  = $clog2(MAX_W);

  // Bit 0 of the command is sampled in IDLE, so CMD itself sees CMD_W-1 bits.
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_W - 2);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_MSG, ST_KEY, ST_START, ST_WAIT, ST_SEND, ST_END
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CMD_W-2:0]   cmd_sh;
  logic [KEY_W-2:0]   key_sh;
  logic [DATA_W-2:0]  res_sh;
  logic [CMD_W-1:0]   cmd_full;
  logic               cmd_ok;
  logic               cmd_done;
  logic               bad_cmd;
  logic               abort;
  logic               reuse_q;

  assign cmd_full = {SIMO, cmd_sh};
  assign cmd_done = (state == ST_CMD) && !cs_n && (cnt == CMD_LAST);
  assign bad_cmd  = cmd_done && !cmd_ok;
  assign abort    = cs_n && ((state == ST_CMD) || (state == ST_MSG) || (state == ST_KEY));

`ifdef SPI_SLAVE_KEY_REUSE_EN
  assign cmd_ok = (cmd_full[CMD_W-1:2] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reuse_q <= 1'b0;
    end else if (cmd_done && cmd_ok) begin
      reuse_q <= cmd_full[1];
    end
  end
`else
  assign cmd_ok  = (cmd_full[CMD_W-1:1] == '0);
  assign reuse_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!cs_n) state_nxt = ST_CMD;
      ST_CMD: begin
        if (cs_n)          state_nxt = ST_IDLE;
        else if (cmd_done) state_nxt = cmd_ok ? ST_MSG : ST_END;
      end
      ST_MSG: begin
        if (cs_n)                  state_nxt = ST_IDLE;
        else if (cnt == MSG_LAST)  state_nxt = reuse_q ? ST_START : ST_KEY;
      end
      ST_KEY: begin
        if (cs_n)                  state_nxt = ST_IDLE;
        else if (cnt == KEY_LAST)  state_nxt = ST_START;
      end
      ST_START: state_nxt = core_done ? ST_SEND : ST_WAIT;
      ST_WAIT:  if (core_done) state_nxt = ST_SEND;
      ST_SEND:  if (cnt == MSG_LAST) state_nxt = ST_END;
      ST_END:   if (cs_n) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    core_start = (state == ST_START);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      cmd_sh       <= '0;
      key_sh       <= '0;
      res_sh       <= '0;
      core_msg     <= '0;
      core_key     <= '0;
      core_decrypt <= 1'b0;
      SOMI         <= 1'b0;
      err          <= 1'b0;
    end else begin
      err <= abort || bad_cmd;
      cnt <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          if (!cs_n) cmd_sh <= {SIMO, cmd_sh[CMD_W-2:1]};
        end
        ST_CMD: begin
          if (cmd_done) begin
            if (cmd_ok) core_decrypt <= cmd_full[0];
          end else if (!cs_n) begin
            cmd_sh <= {SIMO, cmd_sh[CMD_W-2:1]};
          end
        end
        ST_MSG: begin
          if (!cs_n) core_msg <= {SIMO, core_msg[DATA_W-1:1]};
        end
        ST_KEY: begin
          // Key is staged so an aborted frame leaves core_key untouched.
          if (!cs_n) begin
            if (cnt == KEY_LAST) core_key <= {SIMO, key_sh};
            else                 key_sh   <= {SIMO, key_sh[KEY_W-2:1]};
          end
        end
        ST_START, ST_WAIT: begin
          if (core_done) begin
            SOMI   <= core_result[0];
            res_sh <= core_result[DATA_W-1:1];
          end
        end
        ST_SEND: begin
          if (cnt == MSG_LAST) begin
            SOMI <= 1'b0;
          end else begin
            SOMI   <= res_sh[0];
            res_sh <= res_sh >> 1;
          end
        end
        ST_END:  SOMI <= 1'b0;
        default: SOMI <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_frame_slave.sv
// Directed + randomized frames against a frame-level reference model of aes_spi_frame_slave.
// The core is emulated inline: a one-cycle core_done with a chosen result after a chosen latency.
module tb_aes_spi_frame_slave;
  localparam int DATA_W = 128;
  localparam int KEY_W  = 128;
  localparam int CMD_W  = 8;
`ifdef SPI_SLAVE_KEY_REUSE_EN
  localparam bit REUSE_EN = 1'b1;
`else
  localparam bit REUSE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, cs_n, SIMO, SOMI, core_start, core_decrypt, core_done, busy, err;
  logic [DATA_W-1:0] core_msg, core_result;
  logic [KEY_W-1:0]  core_key;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0;
  int err_cnt   = 0;
  logic [KEY_W-1:0] model_key;

  always #5 clk = ~clk;

  aes_spi_frame_slave #(.DATA_W(DATA_W), .KEY_W(KEY_W), .CMD_W(CMD_W)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .SIMO(SIMO), .SOMI(SOMI),
    .core_start(core_start), .core_msg(core_msg), .core_key(core_key),
    .core_decrypt(core_decrypt), .core_done(core_done), .core_result(core_result),
    .busy(busy), .err(err)
  );

  always @(posedge clk) begin
    if (core_start) start_cnt++;
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W; i++) v[i] = 1'($urandom);
    return v;
  endfunction

  function automatic logic [KEY_W-1:0] rnd_key();
    logic [KEY_W-1:0] v;
    for (int i = 0; i < KEY_W; i++) v[i] = 1'($urandom);
    return v;
  endfunction

  function automatic logic [511:0] make_frame(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] m,
                                              input logic [KEY_W-1:0] k);
    logic [511:0] f;
    f = '0;
    f[CMD_W-1:0]             = c;
    f[CMD_W +: DATA_W]       = m;
    f[CMD_W+DATA_W +: KEY_W] = k;
    return f;
  endfunction

  // Bit i of the frame goes out on the i-th clk edge with cs_n low.
  task automatic send_bits(input logic [511:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cs_n = 1'b0;
      SIMO = f[i];
      @(posedge clk);
    end
  endtask

  task automatic run_frame(input logic [CMD_W-1:0] cmd, input logic [DATA_W-1:0] msg,
                           input logic [KEY_W-1:0] key, input logic [DATA_W-1:0] res,
                           input int lat, input bit early);
    logic [DATA_W-1:0] got;
    bit reuse;
    int s0, e0;
    reuse = REUSE_EN && cmd[1];
    s0 = start_cnt;
    e0 = err_cnt;
    send_bits(make_frame(cmd, msg, key), reuse ? CMD_W + DATA_W : CMD_W + DATA_W + KEY_W);
    if (!reuse) model_key = key;
    @(negedge clk);
    check("start_after_last_bit", core_start, 1'b1);
    check("core_msg", core_msg, msg);
    check("core_key", core_key, model_key);
    check("core_decrypt", core_decrypt, cmd[0]);
    if (early) cs_n = 1'b1;
    for (int i = 0; i < lat; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    core_done   = 1'b1;
    core_result = res;
    @(posedge clk);
    @(negedge clk);
    core_done   = 1'b0;
    core_result = rnd_data();
    for (int k = 0; k < DATA_W; k++) begin
      got[k] = SOMI;
      SIMO = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    check("somi_stream", got, res);
    check("somi_zero_in_end", SOMI, 1'b0);
    check("busy_in_end", busy, 1'b1);
    cs_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("busy_back_idle", busy, 1'b0);
    check("start_pulses", start_cnt - s0, 1);
    check("no_err_good_frame", err_cnt - e0, 0);
  endtask

  task automatic abort_frame(input int n, input string tag);
    int s0, e0;
    s0 = start_cnt;
    e0 = err_cnt;
    send_bits(make_frame({{(CMD_W-1){1'b0}}, 1'($urandom)}, rnd_data(), rnd_key()), n);
    @(negedge clk);
    cs_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_err"}, err, 1'b1);
    check({tag, "_idle"}, busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_err_one_cycle"}, err, 1'b0);
    check({tag, "_key_kept"}, core_key, model_key);
    check({tag, "_no_start"}, start_cnt - s0, 0);
    check({tag, "_err_count"}, err_cnt - e0, 1);
  endtask

  task automatic bad_cmd(input logic [CMD_W-1:0] cmd);
    int s0, e0;
    s0 = start_cnt;
    e0 = err_cnt;
    send_bits(make_frame(cmd, '0, '0), CMD_W);
    @(negedge clk);
    check("badcmd_err", err, 1'b1);
    check("badcmd_busy", busy, 1'b1);
    for (int i = 0; i < 20; i++) begin
      SIMO = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    check("badcmd_busy_held", busy, 1'b1);
    check("badcmd_somi", SOMI, 1'b0);
    cs_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("badcmd_idle", busy, 1'b0);
    check("badcmd_no_start", start_cnt - s0, 0);
    check("badcmd_err_count", err_cnt - e0, 1);
  endtask

  initial begin
    logic [DATA_W-1:0] m;
    logic [KEY_W-1:0]  k;
    logic              somi_or;
    rst = 1'b1; cs_n = 1'b1; SIMO = 1'b0; core_done = 1'b0; core_result = '0;
    model_key = '0;
    repeat (3) @(negedge clk);
    check("rst_somi", SOMI, 1'b0);
    check("rst_start", core_start, 1'b0);
    check("rst_msg", core_msg, '0);
    check("rst_key", core_key, '0);
    check("rst_decrypt", core_decrypt, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    run_frame(8'h00, 128'h3243f6a8885a308d313198a2e0370734, k,
              128'h3925841d02dc09fbdc118597196a0b32, 5, 1'b0);
    run_frame(8'h01, rnd_data(), k, rnd_data(), $urandom_range(0, 6), 1'b0);
    run_frame(8'h00, rnd_data(), rnd_key(), rnd_data(), 0, 1'b1);

    abort_frame(CMD_W + 50, "abort_msg");
    abort_frame(CMD_W + DATA_W + $urandom_range(1, KEY_W - 1), "abort_key");
    abort_frame(3, "abort_cmd");

    bad_cmd(8'h80);
    bad_cmd(8'h80 | CMD_W'($urandom));
`ifdef SPI_SLAVE_KEY_REUSE_EN
    run_frame(8'h02, rnd_data(), rnd_key(), rnd_data(), 2, 1'b0);
`else
    bad_cmd(8'h02);
`endif

    for (int i = 0; i < 4; i++) begin
      run_frame({{(CMD_W-1){1'b0}}, 1'($urandom)}, rnd_data(), rnd_key(), rnd_data(),
                $urandom_range(0, 6), 1'($urandom));
    end

    // Reset while the core is busy; its late done must be ignored.
    m = rnd_data();
    send_bits(make_frame(8'h01, m, rnd_key()), CMD_W + DATA_W + KEY_W);
    @(negedge clk);
    check("rw_start", core_start, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rw_somi", SOMI, 1'b0);
    check("rw_start_low", core_start, 1'b0);
    check("rw_msg", core_msg, '0);
    check("rw_key", core_key, '0);
    check("rw_decrypt", core_decrypt, 1'b0);
    check("rw_busy", busy, 1'b0);
    check("rw_err", err, 1'b0);
    model_key = '0;
    cs_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    core_done = 1'b1;
    core_result = '1;
    @(posedge clk);
    @(negedge clk);
    core_done = 1'b0;
    somi_or = 1'b0;
    for (int i = 0; i < 10; i++) begin
      somi_or |= SOMI;
      @(posedge clk);
      @(negedge clk);
    end
    check("rw_somi_quiet", somi_or, 1'b0);
    check("rw_idle", busy, 1'b0);
    run_frame(8'h00, rnd_data(), rnd_key(), rnd_data(), 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_spi_frame_slave.md
# aes_spi_frame_slave

Parametrised serial front end for the AES core: receives a framed command, message block and key over a single-bit serial input, launches one AES operation, and returns the result serially. It generalises the fixed-width serial slave to configurable block and key widths and adds a command header with an encrypt/decrypt select, frame abort and error reporting. It sits between the SPI master pins and the AES encrypt/decrypt core.

## Interface
- DATA_W, 128, message/result block width in bits
- KEY_W, 128, key width in bits; legal values 128, 192, 256
- CMD_W, 8, command header width in bits
- clk  in  1  system clock; all serial bits are sampled and driven on its rising edge
- rst  in  1  asynchronous, active-high reset
- cs_n  in  1  frame enable, active low
- SIMO  in  1  serial data in, LSB first
- SOMI  out  1  serial data out, LSB first, registered
- core_start  out  1  one-cycle pulse that launches the AES core
- core_msg  out  DATA_W  message block, stable from core_start until core_done
- core_key  out  KEY_W  key, stable from core_start until core_done
- core_decrypt  out  1  1 = decrypt, 0 = encrypt
- core_done  in  1  one-cycle completion pulse from the core
- core_result  in  DATA_W  core output, valid while core_done = 1
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on a bad command or an aborted frame

## Operation
- FSM states: IDLE, CMD, MSG, KEY, START, WAIT, SEND, END.
- IDLE: on the first clk edge with cs_n = 0, SIMO is sampled as command bit 0 and the FSM moves to CMD.
- CMD: collects CMD_W bits in total.
  - cmd[0] selects decrypt.
  - cmd[1] selects key reuse; it is legal only under the macro.
  - All other bits must be 0.
  - An illegal command pulses err and goes to END.
- MSG: collects DATA_W bits into core_msg (bit i = i-th sampled bit).
- KEY: collects KEY_W bits into core_key. When the key is reused, KEY is skipped and MSG goes straight to START.
- START: asserts core_start for exactly one cycle, then goes to WAIT.
- WAIT: holds until core_done. On core_done, core_result is latched into the shift register and the FSM goes to SEND.
- SEND: shifts DATA_W bits out on SOMI, one per clk, LSB first, independent of cs_n. Goes to END afterwards.
- END: waits for cs_n = 1, then returns to IDLE. SOMI = 0.
- Abort: cs_n = 1 during CMD, MSG or KEY pulses err and returns to IDLE. Partially received data is discarded; core_key keeps its previous value.
- cs_n = 1 during START, WAIT or SEND has no effect.
- A bit counter of width clog2(max(DATA_W, KEY_W, CMD_W)) is cleared on every state change.

## Timing
- Reset values: SOMI 0, core_start 0, core_msg 0, core_key 0, core_decrypt 0, busy 0, err 0. The FSM resets to IDLE.
- Reset is asynchronous and valid in any state, including mid-frame and WAIT. A core_done arriving after reset is ignored.
- Frame length in clk cycles with cs_n low: CMD_W + DATA_W + KEY_W (CMD_W + DATA_W when the key is reused).
- core_start is high on the cycle after the last key bit is sampled.
- SOMI carries result[0] on the cycle after the core_done edge and result[DATA_W-1] DATA_W-1 cycles later.
- END is entered on the cycle after the last bit is driven.
- busy rises on the edge that samples command bit 0 and falls on the edge that returns the FSM to IDLE.
- core_done arriving in the same cycle as core_start is treated as done.

## Configuration
- SPI_SLAVE_KEY_REUSE_EN
  - Defined: cmd[1] = 1 skips the KEY phase and reuses the last loaded core_key. After reset the reused key is all zeros.
  - Undefined: cmd[1] = 1 is an illegal command (err pulse, go to END). Every frame carries a key.

## Test plan
- Encrypt, 128-bit:
  - Stimulus: cmd 0x00, msg 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c. The core stub returns 3925841d02dc09fbdc118597196a0b32 five cycles after core_start.
  - Response: core_start pulses at cycle 264, core_decrypt = 0, and SOMI streams 3925841d…0b32 LSB first.
- Decrypt: cmd 0x01 with the same key -> core_decrypt = 1 and core_msg/core_key match the shifted values bit-exactly.
- Abort: cs_n rises after 50 message bits -> one err pulse, return to IDLE, core_start never asserted, core_key unchanged.
- Bad command: cmd 0x80 -> err pulse, busy held until cs_n = 1, no core_start.
- Reset mid-WAIT: rst asserted, then a late core_done -> all outputs at reset values, SOMI stays 0, FSM in IDLE.
- Key reuse: KEY_W = 256 build, second frame with cmd 0x02 -> frame is 136 bits; behaviour with and without SPI_SLAVE_KEY_REUSE_EN as specified under Configuration.
